// File: rtl/fixed_point_addsub_pipe_if.sv
// Handshake bundle for the saturating fixed-point add/sub pipeline.
// The slave modport faces the arithmetic unit; the master modport faces its driver.
interface fixed_point_addsub_pipe_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         acc_clear;
  logic         clear_sticky;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic         out_saturated;
  logic         sticky_saturated;

  modport slave (
    input  in_valid, in_op, in_a, in_b, acc_clear, clear_sticky, out_ready,
    output in_ready, out_valid, out_result, out_saturated, sticky_saturated
  );

  modport master (
    output in_valid, in_op, in_a, in_b, acc_clear, clear_sticky, out_ready,
    input  in_ready, out_valid, out_result, out_saturated, sticky_saturated
  );
endinterface

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage stall-all pipeline computing saturating signed Q(INT.FRAC) add, sub,
// negate and accumulate, with per-result and sticky saturation flags.
module fixed_point_addsub_pipe #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fixed_point_addsub_pipe_if.slave  bus_if
);
  localparam int N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam logic [N-1:0] MAX_C = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_C = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_ACC = 2'b11
  } op_e;

  // An (N+1)-bit exact result overflows N bits when its top two bits disagree.
  function automatic logic is_ovf(input logic [N:0] x);
    return x[N] ^ x[N-1];
  endfunction

  function automatic logic [N-1:0] clamp(input logic [N:0] x);
    if (x[N] ^ x[N-1]) begin
      return x[N] ? MIN_C : MAX_C;
    end else begin
      return x[N-1:0];
    end
  endfunction

  logic         advance_s, accept_s, transfer_s;
  op_e          op_s;
  logic [N:0]   a_ext_s, b_ext_s, acc_base_s, acc_sum_s, exact_s;
  logic [N-1:0] acc_sat_s;
  logic [N-1:0] acc_d, acc_q;
  logic         s1_valid_d, s1_valid_q;
  logic [N:0]   s1_sum_d, s1_sum_q;
  op_e          s1_op_d, s1_op_q;
  logic         s1_sat_d, s1_sat_q;
  logic         out_valid_d, out_valid_q;
  logic [N-1:0] out_result_d, out_result_q;
  logic         out_sat_d, out_sat_q;
  logic         sticky_d, sticky_q;

  always_comb begin
    advance_s  = !out_valid_q || bus_if.out_ready;
    accept_s   = bus_if.in_valid && advance_s;
    transfer_s = out_valid_q && bus_if.out_ready;
    op_s       = op_e'(bus_if.in_op);
    a_ext_s    = {bus_if.in_a[N-1], bus_if.in_a};
    b_ext_s    = {bus_if.in_b[N-1], bus_if.in_b};
    // A clear arriving with an ACC is applied before the add.
    acc_base_s = bus_if.acc_clear ? {(N+1){1'b0}} : {acc_q[N-1], acc_q};
    acc_sum_s  = acc_base_s + a_ext_s;
    acc_sat_s  = clamp(acc_sum_s);
    exact_s    = {(N+1){1'b0}};
    case (op_s)
      OP_ADD:  exact_s = a_ext_s + b_ext_s;
      OP_SUB:  exact_s = a_ext_s - b_ext_s;
      OP_NEG:  exact_s = {(N+1){1'b0}} - a_ext_s;
      OP_ACC:  exact_s = {acc_sat_s[N-1], acc_sat_s};
      default: exact_s = {(N+1){1'b0}};
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (accept_s && (op_s == OP_ACC)) begin
      acc_d = acc_sat_s;
    end else if (bus_if.acc_clear) begin
      acc_d = {N{1'b0}};
    end else begin
      acc_d = acc_q;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_op_d    = s1_op_q;
    s1_sat_d   = s1_sat_q;
    if (advance_s) begin
      s1_valid_d = accept_s;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept_s) begin
      s1_sum_d = exact_s;
      s1_op_d  = op_s;
      s1_sat_d = (op_s == OP_ACC) && is_ovf(acc_sum_s);
    end else begin
      s1_sum_d = s1_sum_q;
    end
  end

  // ACC results were clamped on entry, so their flag comes from stage 1.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_sat_d    = out_sat_q;
    if (advance_s) begin
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (advance_s && s1_valid_q) begin
      out_result_d = clamp(s1_sum_q);
      out_sat_d    = (s1_op_q == OP_ACC) ? s1_sat_q : is_ovf(s1_sum_q);
    end else begin
      out_result_d = out_result_q;
    end
    if (transfer_s && out_sat_q) begin
      sticky_d = 1'b1;
    end else if (bus_if.clear_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= {N{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= {(N+1){1'b0}};
      s1_op_q      <= OP_ADD;
      s1_sat_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= {N{1'b0}};
      out_sat_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      s1_valid_q   <= s1_valid_d;
      s1_sum_q     <= s1_sum_d;
      s1_op_q      <= s1_op_d;
      s1_sat_q     <= s1_sat_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_sat_q    <= out_sat_d;
      sticky_q     <= sticky_d;
    end
  end

  assign bus_if.in_ready         = advance_s;
  assign bus_if.out_valid        = out_valid_q;
  assign bus_if.out_result       = out_result_q;
  assign bus_if.out_saturated    = out_sat_q;
  assign bus_if.sticky_saturated = sticky_q;
endmodule
